// File: rtl/nco_envelope_if.sv
// Sample/control bundle between the NCO-side driver and the ADSR envelope stage.
interface nco_envelope_if #(
  parameter int unsigned BIT_DEPTH = 8
);
  logic [BIT_DEPTH-1:0] sample_in;
  logic                 gate;
  logic [15:0]          attack_inc;
  logic [15:0]          decay_dec;
  logic [15:0]          sustain_level;
  logic [15:0]          release_dec;
  logic [BIT_DEPTH-1:0] sample_out;
  logic                 out_valid;
  logic [15:0]          env_level;
  logic [2:0]           env_state;

  modport master (
    output sample_in, gate, attack_inc, decay_dec, sustain_level, release_dec,
    input  sample_out, out_valid, env_level, env_state
  );

  modport slave (
    input  sample_in, gate, attack_inc, decay_dec, sustain_level, release_dec,
    output sample_out, out_valid, env_level, env_state
  );
endinterface

// File: rtl/nco_envelope.sv
// ADSR amplitude envelope applied about mid-scale to an offset-binary NCO sample stream.
module nco_envelope #(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned SAMPLE_RATE = 48_000,
  parameter int unsigned BIT_DEPTH   = 8
) (
  input logic           clk,
  input logic           rst,
  nco_envelope_if.slave bus
);

  localparam int unsigned DIV = CLK_FREQ / SAMPLE_RATE;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned PW  = BIT_DEPTH + 18;

  localparam logic [CW-1:0]        CntMax     = CW'(DIV - 1);
  localparam logic [BIT_DEPTH-1:0] SampleHalf = BIT_DEPTH'(1 << (BIT_DEPTH - 1));

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StAttack  = 3'd1;
  localparam logic [2:0] StDecay   = 3'd2;
  localparam logic [2:0] StSustain = 3'd3;
  localparam logic [2:0] StRelease = 3'd4;

  logic [CW-1:0]        cnt_q;
  logic                 tick;
  logic [2:0]           state_q, state_d;
  logic [15:0]          env_q, env_d;
  logic                 gate_q;
  logic [BIT_DEPTH-1:0] sample_q, sample_d;
  logic                 out_valid_q;

  logic                 rise;
  logic [16:0]          att_sum;
  logic signed [16:0]   dec_diff;
  logic                 att_hit, dec_hit, rel_hit;

  logic signed [BIT_DEPTH:0] s;
  logic signed [PW-1:0]      prod;
  logic [BIT_DEPTH-1:0]      p;
  logic                      unused_prod;

  assign tick = (cnt_q == CntMax);

  // Sample-rate divider: counts 0..DIV-1, tick on the last count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign rise     = bus.gate & ~gate_q;
  assign att_sum  = {1'b0, env_q} + {1'b0, bus.attack_inc};
  assign dec_diff = $signed({1'b0, env_q}) - $signed({1'b0, bus.decay_dec});
  assign att_hit  = (att_sum >= 17'd65535) || (bus.attack_inc == '0);
  // Signed compare so an undershoot below zero still lands on the sustain level.
  assign dec_hit  = (dec_diff <= $signed({1'b0, bus.sustain_level})) || (bus.decay_dec == '0);
  assign rel_hit  = (env_q <= bus.release_dec) || (bus.release_dec == '0);

  // Envelope next state: retrigger, then gate release, then per-state progression.
  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    if (rise) begin
      state_d = StAttack;
    end else if (!bus.gate &&
                 (state_q == StAttack || state_q == StDecay || state_q == StSustain)) begin
      state_d = StRelease;
    end else begin
      case (state_q)
        StIdle: env_d = '0;
        StAttack: begin
          if (att_hit) begin
            env_d   = 16'hFFFF;
            state_d = StDecay;
          end else begin
            env_d = att_sum[15:0];
          end
        end
        StDecay: begin
          if (dec_hit) begin
            env_d   = bus.sustain_level;
            state_d = StSustain;
          end else begin
            env_d = dec_diff[15:0];
          end
        end
        StSustain: env_d = bus.sustain_level;
        StRelease: begin
          if (rel_hit) begin
            env_d   = '0;
            state_d = StIdle;
          end else begin
            env_d = env_q - bus.release_dec;
          end
        end
        default: begin
          env_d   = '0;
          state_d = StIdle;
        end
      endcase
    end
  end

  // Scale the signed sample by env/65536; bits above the kept slice are pure sign extension.
  assign s           = $signed({1'b0, bus.sample_in}) - $signed({1'b0, SampleHalf});
  assign prod        = PW'(s) * PW'($signed({1'b0, env_q}));
  assign p           = prod[BIT_DEPTH+15:16];
  assign unused_prod = ^{prod[PW-1:BIT_DEPTH+16], prod[15:0]};
  assign sample_d    = SampleHalf + p;

  // Registered envelope, gate history and output sample, advanced only on ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      env_q       <= '0;
      gate_q      <= 1'b0;
      sample_q    <= SampleHalf;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= tick;
      if (tick) begin
        state_q  <= state_d;
        env_q    <= env_d;
        gate_q   <= bus.gate;
        sample_q <= sample_d;
      end
    end
  end

  assign bus.sample_out = sample_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.env_level  = env_q;
  assign bus.env_state  = state_q;

endmodule

// File: tb/tb_nco_envelope.sv
// Bench for nco_envelope: DIV=4 and DIV=1 instances against an integer ADSR model.
module tb_nco_envelope;

  logic clk;
  logic rst_a, rst_b;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  nco_envelope_if #(.BIT_DEPTH(8)) bus_a ();
  nco_envelope_if #(.BIT_DEPTH(8)) bus_b ();

  nco_envelope #(.CLK_FREQ(4), .SAMPLE_RATE(1), .BIT_DEPTH(8)) dut_a (
    .clk(clk), .rst(rst_a), .bus(bus_a)
  );
  nco_envelope #(.CLK_FREQ(1), .SAMPLE_RATE(1), .BIT_DEPTH(8)) dut_b (
    .clk(clk), .rst(rst_b), .bus(bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic void cmp(input string name, input int act, input int want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, want);
    end
  endfunction

  // Behavioural model: integer envelope rules and floor-scaled amplitude.
  int m_cnt[2], m_st[2], m_env[2], m_out[2], m_vld[2], m_gq[2];

  function automatic int amp(input int smp, input int env);
    int prod;
    prod = (smp - 128) * env;
    if (prod >= 0) return 128 + prod / 65536;
    return 128 - ((-prod + 65535) / 65536);
  endfunction

  task automatic model_clock(input int i, input bit r, input int div, input bit g,
                             input int smp, input int ai, input int dd, input int sl,
                             input int rd);
    int st, env;
    bit tk;
    if (r) begin
      m_cnt[i] = 0; m_st[i] = 0; m_env[i] = 0; m_out[i] = 128; m_vld[i] = 0; m_gq[i] = 0;
    end else begin
      tk = (m_cnt[i] == div - 1);
      m_cnt[i] = tk ? 0 : m_cnt[i] + 1;
      m_vld[i] = tk;
      if (tk) begin
        st = m_st[i];
        env = m_env[i];
        m_out[i] = amp(smp, env);
        if (g && !m_gq[i]) st = 1;
        else if (!g && (st == 1 || st == 2 || st == 3)) st = 4;
        else begin
          case (st)
            0: env = 0;
            1: if (ai == 0 || env + ai >= 65535) begin env = 65535; st = 2; end
               else env = env + ai;
            2: if (dd == 0 || env - dd <= sl) begin env = sl; st = 3; end
               else env = env - dd;
            3: env = sl;
            4: if (rd == 0 || env <= rd) begin env = 0; st = 0; end
               else env = env - rd;
            default: begin env = 0; st = 0; end
          endcase
        end
        m_st[i] = st;
        m_env[i] = env;
        m_gq[i] = g;
      end
    end
  endtask

  // Model advances on the same edges the DUTs do.
  always @(posedge clk) begin
    model_clock(0, rst_a, 4, bus_a.gate, bus_a.sample_in, bus_a.attack_inc, bus_a.decay_dec,
                bus_a.sustain_level, bus_a.release_dec);
    model_clock(1, rst_b, 1, bus_b.gate, bus_b.sample_in, bus_b.attack_inc, bus_b.decay_dec,
                bus_b.sustain_level, bus_b.release_dec);
  end

  // Every-cycle compare of both DUTs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("a_sample_out", bus_a.sample_out, m_out[0]);
      cmp("a_out_valid", bus_a.out_valid, m_vld[0]);
      cmp("a_env_level", bus_a.env_level, m_env[0]);
      cmp("a_env_state", bus_a.env_state, m_st[0]);
      cmp("b_sample_out", bus_b.sample_out, m_out[1]);
      cmp("b_out_valid", bus_b.out_valid, m_vld[1]);
      cmp("b_env_level", bus_b.env_level, m_env[1]);
      cmp("b_env_state", bus_b.env_state, m_st[1]);
    end
  end

  task automatic wait_tick_a(input string name, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_a.out_valid && n < 16);
    if (!bus_a.out_valid) cmp({name, "_timeout"}, 0, 1);
  endtask

  task automatic tick_env(input string name, input int env, input int st);
    int n;
    wait_tick_a(name, n);
    cmp({name, "_env"}, bus_a.env_level, env);
    cmp({name, "_state"}, bus_a.env_state, st);
  endtask

  task automatic tick_amp(input string name, input int smp, input int want);
    int n;
    bus_a.sample_in = 8'(smp);
    wait_tick_a(name, n);
    cmp(name, bus_a.sample_out, want);
  endtask

  int ads_env[8] = '{16384, 32768, 49152, 65535, 55535, 45535, 40000, 40000};
  int ads_st[8]  = '{1, 1, 1, 2, 2, 2, 3, 3};
  int rel_env[4] = '{40000, 25000, 10000, 0};
  int rel_st[4]  = '{4, 4, 4, 0};

  initial begin
    int n;
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.gate = 1'b1;          bus_a.sample_in = 8'd128;
    bus_a.attack_inc = 16'd16384; bus_a.decay_dec = 16'd10000;
    bus_a.sustain_level = 16'd40000; bus_a.release_dec = 16'd15000;
    bus_b.gate = 1'b1;          bus_b.sample_in = 8'd200;
    bus_b.attack_inc = 16'd1000; bus_b.decay_dec = 16'd1000;
    bus_b.sustain_level = 16'd30000; bus_b.release_dec = 16'd1000;

    @(posedge clk);
    chk_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmp("rst_sample_out", bus_a.sample_out, 128);
    cmp("rst_env_level", bus_a.env_level, 0);
    cmp("rst_env_state", bus_a.env_state, 0);
    cmp("rst_out_valid", bus_a.out_valid, 0);

    // DIV=1: tick every cycle, then mid-attack reset.
    rst_b = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      cmp("div1_valid", bus_b.out_valid, 1);
      cmp("div1_env", bus_b.env_level, k * 1000);
      cmp("div1_state", bus_b.env_state, 1);
    end
    rst_b = 1'b1;
    @(negedge clk);
    cmp("midrst_env", bus_b.env_level, 0);
    cmp("midrst_state", bus_b.env_state, 0);
    cmp("midrst_sample", bus_b.sample_out, 128);
    cmp("midrst_valid", bus_b.out_valid, 0);

    // DIV=4: first pulse 4 clocks after release; attack/decay/sustain.
    rst_a = 1'b0;
    wait_tick_a("first_tick", n);
    cmp("first_valid_latency", n, 4);
    cmp("first_tick_env", bus_a.env_level, 0);
    cmp("first_tick_state", bus_a.env_state, 1);
    for (int k = 0; k < 8; k++) tick_env("ads", ads_env[k], ads_st[k]);

    // Release to idle.
    bus_a.gate = 1'b0;
    for (int k = 0; k < 4; k++) tick_env("rel", rel_env[k], rel_st[k]);

    // Amplitude path with zero rates driving straight to sustain.
    bus_a.sustain_level = 16'd32768; bus_a.decay_dec = 16'd0; bus_a.attack_inc = 16'd0;
    bus_a.gate = 1'b1;
    tick_env("amp_att", 0, 1);
    tick_env("amp_dec", 65535, 2);
    tick_env("amp_sus", 32768, 3);
    tick_amp("amp_255_half", 255, 191);
    tick_amp("amp_0_half", 0, 64);
    tick_amp("amp_128_half", 128, 128);
    bus_a.sustain_level = 16'd65535;
    tick_amp("amp_to_full", 128, 128);
    tick_amp("amp_255_full", 255, 254);
    tick_amp("amp_0_full", 0, 0);
    bus_a.sustain_level = 16'd0;
    tick_amp("amp_to_zero", 128, 128);
    tick_amp("amp_200_zero", 200, 128);

    // Retrigger during release with zero attack, gate drop during attack, ignored pulse.
    bus_a.sample_in = 8'd128;
    bus_a.sustain_level = 16'd40000;
    tick_env("rt_sus", 40000, 3);
    bus_a.gate = 1'b0;
    tick_env("rt_rel0", 40000, 4);
    tick_env("rt_rel1", 25000, 4);
    bus_a.gate = 1'b1;
    tick_env("rt_att", 25000, 1);
    tick_env("rt_dec", 65535, 2);
    bus_a.gate = 1'b0;
    tick_env("rt_rel2", 65535, 4);
    bus_a.gate = 1'b1; bus_a.attack_inc = 16'd1000;
    tick_env("rt_att2", 65535, 1);
    bus_a.gate = 1'b0;
    tick_env("rt_drop", 65535, 4);
    bus_a.gate = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus_a.gate = 1'b0;
    tick_env("pulse_ignored", 50535, 4);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
